// File: rtl/z80_pkg.sv
// Shared Z80 definitions for the stack-push block: operation encodings,
// push-sequence state enumeration and the bus phase used by a write cycle.
package z80_pkg;

    // Operation codes presented on the op input; 3 is reserved and runs as PUSH.
    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_CALL = 2'd1,
        OP_RST  = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    // Push sequence: one full memory write cycle for each stacked byte.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H_T1 = 3'd1,
        ST_H_T2 = 3'd2,
        ST_H_T3 = 3'd3,
        ST_L_T1 = 3'd4,
        ST_L_T2 = 3'd5,
        ST_L_T3 = 3'd6
    } state_t;

    // Phase of a single memory write cycle; T2 also covers inserted Tw cycles.
    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_T1   = 2'd1,
        PH_T2   = 2'd2,
        PH_T3   = 2'd3
    } phase_t;

    // The reserved encoding behaves exactly like PUSH.
    function automatic op_t norm_op(input logic [1:0] op_raw);
        op_t res;
        case (op_raw)
            2'd1:    res = OP_CALL;
            2'd2:    res = OP_RST;
            default: res = OP_PUSH;
        endcase
        return res;
    endfunction

    // RST p jumps to page-zero address p*8.
    function automatic logic [15:0] rst_vector(input logic [2:0] p);
        return {8'h00, 2'b00, p, 3'b000};
    endfunction

endpackage

// File: rtl/z80_mem_wr_cycle.sv
// One Z80 memory write cycle (T1, T2 with optional Tw, T3) as seen on the bus.
// The parent sequencer supplies the current phase; this block drives the bus
// strobes and reports when WAIT must stretch T2. Outputs are zero when idle so
// the high-byte and low-byte instances can simply be OR-ed together.
module z80_mem_wr_cycle
    import z80_pkg::*;
(
    input  logic [1:0]  phase,
    input  logic        wait_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    output logic        mreq,
    output logic        wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    output logic        hold
);

    logic active;

    // Bus strobes, gated address/data and the wait-state request for this cycle.
    always_comb begin
        active   = (phase != PH_NONE);
        mreq     = active;
        wr       = (phase == PH_T2) || (phase == PH_T3);
        mem_addr = active ? addr : 16'h0000;
        mem_dout = active ? data : 8'h00;
        hold     = (phase == PH_T2) && !wait_n;
    end

endmodule

// File: rtl/z80_stack_push.sv
// Z80 stack push sequencer for PUSH rr, CALL nn and RST p: writes the high byte
// to sp-1, then the low byte to sp-2, and on completion reports the new stack
// pointer and (for CALL/RST) the new instruction pointer.
// Optional build macro: Z80FI_TRACE_EN adds registered formal-trace outputs.
module z80_stack_push
    import z80_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] push_data,
    input  logic [15:0] target,
    input  logic [2:0]  rst_p,
    input  logic [15:0] sp_in,
    input  logic        wait_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] sp_out,
    output logic [15:0] ip_out,
    output logic        ip_load,
    output logic        mreq,
    output logic        wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout
`ifdef Z80FI_TRACE_EN
    ,
    output logic [15:0] z80fi_mem_waddr,
    output logic [15:0] z80fi_mem_waddr2,
    output logic [7:0]  z80fi_mem_wdata,
    output logic [7:0]  z80fi_mem_wdata2,
    output logic [15:0] z80fi_reg_sp_out
`endif
);

    state_t      state_q, state_d;
    op_t         op_q;
    logic [15:0] data_q, target_q, sp_q;
    logic [2:0]  rstp_q;
    logic        done_q, ip_load_q;
    logic [15:0] sp_out_q, ip_out_q;

    logic [1:0]  hi_phase, lo_phase;
    logic        hi_mreq, hi_wr, hi_hold, lo_mreq, lo_wr, lo_hold;
    logic [15:0] hi_addr, lo_addr;
    logic [7:0]  hi_dout, lo_dout;

    logic        accept, finish;

    assign accept = (state_q == ST_IDLE) && start;
    assign finish = (state_q == ST_L_T3);

    // Map the sequencer state onto the phase of the high- or low-byte write.
    always_comb begin
        hi_phase = PH_NONE;
        lo_phase = PH_NONE;
        case (state_q)
            ST_H_T1: hi_phase = PH_T1;
            ST_H_T2: hi_phase = PH_T2;
            ST_H_T3: hi_phase = PH_T3;
            ST_L_T1: lo_phase = PH_T1;
            ST_L_T2: lo_phase = PH_T2;
            ST_L_T3: lo_phase = PH_T3;
            default: ;
        endcase
    end

    z80_mem_wr_cycle u_wr_hi (
        .phase    (hi_phase),
        .wait_n   (wait_n),
        .addr     (sp_q - 16'd1),
        .data     (data_q[15:8]),
        .mreq     (hi_mreq),
        .wr       (hi_wr),
        .mem_addr (hi_addr),
        .mem_dout (hi_dout),
        .hold     (hi_hold)
    );

    z80_mem_wr_cycle u_wr_lo (
        .phase    (lo_phase),
        .wait_n   (wait_n),
        .addr     (sp_q - 16'd2),
        .data     (data_q[7:0]),
        .mreq     (lo_mreq),
        .wr       (lo_wr),
        .mem_addr (lo_addr),
        .mem_dout (lo_dout),
        .hold     (lo_hold)
    );

    // Next state: walk the two write cycles, stretching T2 while WAIT is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_H_T1;
            ST_H_T1: state_d = ST_H_T2;
            ST_H_T2: if (!hi_hold) state_d = ST_H_T3;
            ST_H_T3: state_d = ST_L_T1;
            ST_L_T1: state_d = ST_L_T2;
            ST_L_T2: if (!lo_hold) state_d = ST_L_T3;
            ST_L_T3: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture the operands once, so later input changes cannot disturb the push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_PUSH;
            data_q   <= 16'h0000;
            target_q <= 16'h0000;
            rstp_q   <= 3'd0;
            sp_q     <= 16'h0000;
        end else if (accept) begin
            op_q     <= norm_op(op);
            data_q   <= push_data;
            target_q <= target;
            rstp_q   <= rst_p;
            sp_q     <= sp_in;
        end
    end

    // Completion results, published in the first idle cycle after the low T3.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q    <= 1'b0;
            ip_load_q <= 1'b0;
            sp_out_q  <= 16'hFFFF;
            ip_out_q  <= 16'h0000;
        end else begin
            done_q    <= finish;
            ip_load_q <= finish && (op_q != OP_PUSH);
            if (finish) begin
                sp_out_q <= sp_q - 16'd2;
                if (op_q == OP_CALL)     ip_out_q <= target_q;
                else if (op_q == OP_RST) ip_out_q <= rst_vector(rstp_q);
            end
        end
    end

`ifdef Z80FI_TRACE_EN
    // Trace record of both stack writes, valid from the done cycle onwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z80fi_mem_waddr  <= 16'h0000;
            z80fi_mem_waddr2 <= 16'h0000;
            z80fi_mem_wdata  <= 8'h00;
            z80fi_mem_wdata2 <= 8'h00;
            z80fi_reg_sp_out <= 16'h0000;
        end else if (finish) begin
            z80fi_mem_waddr  <= sp_q - 16'd1;
            z80fi_mem_waddr2 <= sp_q - 16'd2;
            z80fi_mem_wdata  <= data_q[15:8];
            z80fi_mem_wdata2 <= data_q[7:0];
            z80fi_reg_sp_out <= sp_q - 16'd2;
        end
    end
`endif

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ip_load  = ip_load_q;
    assign sp_out   = sp_out_q;
    assign ip_out   = ip_out_q;
    assign mreq     = hi_mreq | lo_mreq;
    assign wr       = hi_wr | lo_wr;
    assign mem_addr = hi_addr | lo_addr;
    assign mem_dout = hi_dout | lo_dout;

endmodule

// File: tb/tb_z80_stack_push.sv
// Self-checking bench for z80_stack_push: directed corner cases followed by
// random pushes. The reference is a per-cycle list of expected bus activity
// built from the write-cycle rules (T1, T2 + waits, T3 per byte, then done).
module tb_z80_stack_push;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [15:0] push_data = 16'h0000;
    logic [15:0] target = 16'h0000;
    logic [2:0]  rst_p = 3'd0;
    logic [15:0] sp_in = 16'h0000;
    logic        wait_n = 1'b1;
    logic        busy, done, ip_load, mreq, wr;
    logic [15:0] sp_out, ip_out, mem_addr;
    logic [7:0]  mem_dout;
`ifdef Z80FI_TRACE_EN
    logic [15:0] tr_waddr, tr_waddr2, tr_sp;
    logic [7:0]  tr_wdata, tr_wdata2;
`endif

    z80_stack_push dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .push_data (push_data),
        .target    (target),
        .rst_p     (rst_p),
        .sp_in     (sp_in),
        .wait_n    (wait_n),
        .busy      (busy),
        .done      (done),
        .sp_out    (sp_out),
        .ip_out    (ip_out),
        .ip_load   (ip_load),
        .mreq      (mreq),
        .wr        (wr),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout)
`ifdef Z80FI_TRACE_EN
        ,
        .z80fi_mem_waddr  (tr_waddr),
        .z80fi_mem_waddr2 (tr_waddr2),
        .z80fi_mem_wdata  (tr_wdata),
        .z80fi_mem_wdata2 (tr_wdata2),
        .z80fi_reg_sp_out (tr_sp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_sp = 16'hFFFF;
    logic [15:0] exp_ip = 16'h0000;

    typedef struct {
        logic        mreq;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        wait_n;
        logic        done;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Expected bus cycles of one byte write: T1, T2 (+ w wait states), T3.
    task automatic model_byte(input logic [15:0] a, input logic [7:0] d, input int w);
        exp_q.push_back('{mreq: 1'b1, wr: 1'b0, addr: a, dout: d, wait_n: 1'b1, done: 1'b0});
        for (int i = 0; i < w; i++)
            exp_q.push_back('{mreq: 1'b1, wr: 1'b1, addr: a, dout: d, wait_n: 1'b0, done: 1'b0});
        exp_q.push_back('{mreq: 1'b1, wr: 1'b1, addr: a, dout: d, wait_n: 1'b1, done: 1'b0});
        exp_q.push_back('{mreq: 1'b1, wr: 1'b1, addr: a, dout: d, wait_n: 1'b1, done: 1'b0});
    endtask

    // Issue one operation (DUT idle or in its done cycle, mid-cycle) and check
    // every cycle up to and including done. Returns mid-way through done cycle.
    task automatic run_txn(input logic [1:0] o, input logic [15:0] d, input logic [15:0] t,
                           input logic [2:0] rp, input logic [15:0] sp, input int wh,
                           input int wl, input bit mid_start, input string name);
        logic [15:0] sp_hi, sp_lo, new_ip;
        logic        exp_load;
        int          ncyc;
        sp_hi = sp - 16'd1;
        sp_lo = sp - 16'd2;
        start = 1'b1; op = o; push_data = d; target = t; rst_p = rp; sp_in = sp; wait_n = 1'b1;
        exp_q.delete();
        model_byte(sp_hi, d[15:8], wh);
        model_byte(sp_lo, d[7:0], wl);
        exp_q.push_back('{mreq: 1'b0, wr: 1'b0, addr: 16'h0000, dout: 8'h00, wait_n: 1'b1, done: 1'b1});
        exp_load = (o == 2'd1) || (o == 2'd2);
        new_ip   = (o == 2'd1) ? t : (o == 2'd2) ? {8'h00, 2'b00, rp, 3'b000} : exp_ip;
        ncyc = exp_q.size();
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start  = mid_start && (c == 3);
            if (start) begin
                op = 2'($urandom); push_data = 16'($urandom); target = 16'($urandom);
                rst_p = 3'($urandom); sp_in = 16'($urandom);
            end
            wait_n = exp_q[c-1].wait_n;
            @(negedge clk);
            chk({name, ".mreq"}, {31'd0, mreq}, {31'd0, exp_q[c-1].mreq});
            chk({name, ".wr"},   {31'd0, wr},   {31'd0, exp_q[c-1].wr});
            chk({name, ".busy"}, {31'd0, busy}, {31'd0, !exp_q[c-1].done});
            chk({name, ".done"}, {31'd0, done}, {31'd0, exp_q[c-1].done});
            if (exp_q[c-1].mreq) begin
                chk({name, ".addr"}, {16'd0, mem_addr}, {16'd0, exp_q[c-1].addr});
                chk({name, ".dout"}, {24'd0, mem_dout}, {24'd0, exp_q[c-1].dout});
            end
            if (exp_q[c-1].done) begin
                exp_sp = sp_lo;
                exp_ip = new_ip;
                chk({name, ".ip_load"}, {31'd0, ip_load}, {31'd0, exp_load});
`ifdef Z80FI_TRACE_EN
                chk({name, ".tr_waddr"},  {16'd0, tr_waddr},  {16'd0, sp_hi});
                chk({name, ".tr_waddr2"}, {16'd0, tr_waddr2}, {16'd0, sp_lo});
                chk({name, ".tr_wdata"},  {24'd0, tr_wdata},  {24'd0, d[15:8]});
                chk({name, ".tr_wdata2"}, {24'd0, tr_wdata2}, {24'd0, d[7:0]});
                chk({name, ".tr_sp"},     {16'd0, tr_sp},     {16'd0, sp_lo});
`endif
            end else begin
                chk({name, ".ip_load_low"}, {31'd0, ip_load}, 32'd0);
            end
            chk({name, ".sp_out"}, {16'd0, sp_out}, {16'd0, exp_sp});
            chk({name, ".ip_out"}, {16'd0, ip_out}, {16'd0, exp_ip});
        end
        start = 1'b0;
    endtask

    // One quiet cycle: done must have dropped and results must be held.
    task automatic idle_step(input string name);
        @(posedge clk); #1;
        start = 1'b0; wait_n = 1'b1;
        @(negedge clk);
        chk({name, ".idle_done"}, {31'd0, done}, 32'd0);
        chk({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({name, ".idle_mreq"}, {31'd0, mreq}, 32'd0);
        chk({name, ".idle_wr"},   {31'd0, wr},   32'd0);
        chk({name, ".idle_load"}, {31'd0, ip_load}, 32'd0);
        chk({name, ".idle_sp"},   {16'd0, sp_out}, {16'd0, exp_sp});
        chk({name, ".idle_ip"},   {16'd0, ip_out}, {16'd0, exp_ip});
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".busy"},    {31'd0, busy},    32'd0);
        chk({name, ".done"},    {31'd0, done},    32'd0);
        chk({name, ".ip_load"}, {31'd0, ip_load}, 32'd0);
        chk({name, ".mreq"},    {31'd0, mreq},    32'd0);
        chk({name, ".wr"},      {31'd0, wr},      32'd0);
        chk({name, ".addr"},    {16'd0, mem_addr}, 32'd0);
        chk({name, ".dout"},    {24'd0, mem_dout}, 32'd0);
        chk({name, ".ip_out"},  {16'd0, ip_out},  32'd0);
        chk({name, ".sp_out"},  {16'd0, sp_out},  32'h0000FFFF);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        $display("step reset: checks=%0d", n_checks);

        run_txn(2'd0, 16'h1234, 16'h0000, 3'd0, 16'h8000, 0, 0, 1'b0, "push");
        idle_step("push");
        $display("step push 0x1234@0x8000: sp_out=0x%0h", sp_out);

        run_txn(2'd1, 16'h0103, 16'hC350, 3'd0, 16'h0000, 0, 0, 1'b0, "call");
        idle_step("call");
        $display("step call 0xC350 sp=0x0000: ip_out=0x%0h", ip_out);

        run_txn(2'd2, 16'hBEEF, 16'h5555, 3'd7, 16'h0001, 0, 0, 1'b0, "rst7");
        idle_step("rst7");
        $display("step rst 7 sp=0x0001: ip_out=0x%0h", ip_out);

        run_txn(2'd0, 16'hA55A, 16'h0000, 3'd0, 16'h4000, 3, 0, 1'b0, "wait3");
        idle_step("wait3");
        $display("step push with 3 waits: sp_out=0x%0h", sp_out);

        // Start pulse mid-sequence is ignored; start in done cycle chains.
        run_txn(2'd1, 16'h2222, 16'h1357, 3'd0, 16'h9000, 0, 0, 1'b1, "mid");
        run_txn(2'd0, 16'h3333, 16'h0000, 3'd0, 16'h7000, 0, 0, 1'b0, "b2b");
        idle_step("b2b");
        $display("step mid-start + back-to-back: sp_out=0x%0h", sp_out);

        run_txn(2'd3, 16'h4444, 16'hFFFF, 3'd5, 16'h1000, 0, 1, 1'b0, "op3");
        idle_step("op3");
        $display("step reserved op: ip_out=0x%0h", ip_out);

        // Reset during the low-byte T2: everything drops at once, no done.
        start = 1'b1; op = 2'd1; push_data = 16'h6666; target = 16'h8888; sp_in = 16'h2000;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("rst_mid.pre_wr", {31'd0, wr}, 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("rst_mid");
        exp_sp = 16'hFFFF;
        exp_ip = 16'h0000;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 4; i++) idle_step("rst_mid");
        $display("step reset in L_T2: sp_out=0x%0h", sp_out);

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [15:0] rd, rt, rs;
            logic [2:0]  rp;
            int          rwh, rwl;
            bit          rmid, rchain;
            ro  = 2'($urandom); rd = 16'($urandom); rt = 16'($urandom);
            rs  = 16'($urandom); rp = 3'($urandom);
            rwh = int'($urandom_range(0, 3)); rwl = int'($urandom_range(0, 3));
            rmid = bit'($urandom_range(0, 1)); rchain = bit'($urandom_range(0, 1));
            run_txn(ro, rd, rt, rp, rs, rwh, rwl, rmid, "rand");
            $display("rand %0d: op=%0d data=0x%0h sp=0x%0h waits=%0d/%0d sp_out=0x%0h ip_out=0x%0h",
                     k, ro, rd, rs, rwh, rwl, sp_out, ip_out);
            if (!rchain) idle_step("rand");
        end
        idle_step("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/z80_stack_push.md
Z80_STACK_PUSH -- requirements
Module: z80_stack_push

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  begin a push sequence; sampled only while idle.
REQ-004 SHALL have port op  input  2  operation: PUSH=0, CALL=1, RST=2; 3 is reserved.
REQ-005 SHALL have port push_data  input  16  value to push (register pair or return address).
REQ-006 SHALL have port target  input  16  CALL jump address.
REQ-007 SHALL have port rst_p  input  3  RST vector index.
REQ-008 SHALL have port sp_in  input  16  stack pointer before the operation.
REQ-009 SHALL have port wait_n  input  1  Z80 WAIT, active-low.
REQ-010 SHALL have outputs busy(1), done(1), sp_out(16), ip_out(16), ip_load(1), mreq(1), wr(1), mem_addr(16), mem_dout(8).

Function
REQ-011 SHALL latch op, push_data, target, rst_p and sp_in on the edge where start=1 and state=IDLE.
REQ-012 SHALL ignore start while busy=1, with no effect on the operation in flight.
REQ-013 SHALL sequence the states IDLE -> H_T1 -> H_T2 -> H_T3 -> L_T1 -> L_T2 -> L_T3 -> IDLE.
REQ-014 SHALL hold in H_T2 or L_T2 (Tw) while wait_n=0, sampled at the end of each T2/Tw cycle.
REQ-015 SHALL drive mem_addr=sp-1 and mem_dout=push_data[15:8] for H_T1..H_T3.
REQ-016 SHALL drive mem_addr=sp-2 and mem_dout=push_data[7:0] for L_T1..L_T3.
REQ-017 SHALL compute all address arithmetic modulo 2^16 (sp=0x0000 -> 0xFFFF, then 0xFFFE).
REQ-018 SHALL assert mreq in every T1/T2/Tw/T3 cycle and wr in every T2/Tw/T3 cycle; both SHALL be 0 otherwise.
REQ-019 SHALL drive busy=1 in every non-IDLE state.
REQ-020 SHALL pulse done=1 for exactly one cycle, in the first IDLE cycle after L_T3.
REQ-021 SHALL update sp_out to sp-2 in the done cycle and hold it until the next done.
REQ-022 SHALL set ip_out=target for CALL and ip_out={8'h00,2'b00,rst_p,3'b000} for RST, and pulse ip_load together with done.
REQ-023 SHALL keep ip_load=0 and ip_out unchanged for PUSH.
REQ-024 SHALL treat op=3 as PUSH.
REQ-025 SHALL complete in 7 cycles (start edge to done) with no waits, plus 1 cycle per Tw.
REQ-026 SHALL accept start in the done cycle, giving back-to-back sequences with no idle gap.

Reset
REQ-027 SHALL on reset, immediately and regardless of clk, enter IDLE and drive busy=0, done=0, ip_load=0, mreq=0, wr=0, mem_addr=0x0000, mem_dout=0x00, ip_out=0x0000, sp_out=0xFFFF.
REQ-028 SHALL abandon any in-flight sequence on reset, with no done and no partial sp_out update.

Configuration
REQ-029 SHALL, with Z80FI_TRACE_EN defined, add outputs z80fi_mem_waddr(16), z80fi_mem_waddr2(16), z80fi_mem_wdata(8), z80fi_mem_wdata2(8) and z80fi_reg_sp_out(16), all registered and valid in the done cycle.
REQ-030 SHALL, in the trace outputs, report waddr=sp-1 and wdata=high byte, waddr2=sp-2 and wdata2=low byte, and hold them until the next done; their reset value SHALL be 0.
REQ-031 SHALL, without Z80FI_TRACE_EN, omit those ports and leave all other behaviour cycle-identical.

Structure
REQ-032 SHALL take the op encodings (PUSH/CALL/RST) and the state enumeration from the shared package z80_pkg.
REQ-033 SHALL implement the single T1/T2(Tw)/T3 write cycle in sub-module z80_mem_wr_cycle, reused for the high and low bytes.

Verification
REQ-034 SHALL cover PUSH: sp_in=0x8000, push_data=0x1234, wait_n=1 -> writes 0x12@0x7FFF then 0x34@0x7FFE; done at cycle 7; sp_out=0x7FFE; ip_load=0.
REQ-035 SHALL cover CALL: target=0xC350, push_data=0x0103, sp_in=0x0000 -> writes 0x01@0xFFFF, 0x03@0xFFFE; sp_out=0xFFFE; ip_out=0xC350 with ip_load pulse.
REQ-036 SHALL cover RST: rst_p=7 -> ip_out=0x0038; and sp_in=0x0001 -> write addresses 0x0000 then 0xFFFF.
REQ-037 SHALL cover waits: wait_n=0 for 3 cycles in H_T2 -> mreq/wr held, mem_addr stable, done at cycle 10.
REQ-038 SHALL cover reset asserted in L_T2 -> mreq=wr=busy=0 immediately, no done, sp_out=0xFFFF.
REQ-039 SHALL cover a start pulse mid-sequence (ignored) and a start in the done cycle (next sequence begins at once; second done at cycle 14).
